demux_word_router: RTL and testbench

Registered 1-to-2 bit-stream demultiplexer with per-channel word assembly and output buffering. It accepts a serial bit stream with a per-bit channel select over a valid/ready handshake. It steers each bit to channel 0 or channel 1 and packs WIDTH bits per channel into a word. Each channel presents its word on an independent valid/ready output. It sits directly downstream of the 1-bit demux data path and turns the raw y0/y1 bit traffic into flow-controlled words for the consumers.

---
 rtl/demux_word_router.sv | 100 ++++++++++
 tb/tb_demux_word_router.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_word_router.sv
// Purpose : steer a serial bit stream to one of two channels and pack WIDTH bits (LSB first) per word.
// Latency : the completing bit's acceptance edge loads outN_data/outN_valid (visible right after that edge).
// Backpr. : in_ready drops only when the selected channel's completing bit would overwrite an unconsumed word.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_bit, in_sel, in_valid    serial bit, destination channel, bit valid
//   in_ready                    bit accepted this cycle (combinational from in_sel, outN_ready, state)
//   out0_data/valid/ready       channel 0 word handshake
//   out1_data/valid/ready       channel 1 word handshake
module demux_word_router #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("demux_word_router: WIDTH must be within 2..32");
  end

  localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  // Per-channel state, index 0/1 = channel 0/1.
  logic [1:0][CW-1:0]    cnt_q;
  logic [1:0][WIDTH-2:0] sreg_q;
  logic [1:0][WIDTH-1:0] data_q;
  logic [1:0]            vld_q;

  logic [1:0]            out_rdy;
  logic [1:0]            at_last;
  logic [1:0]            take;
  logic [1:0][WIDTH-2:0] asm_next;
  logic                  sel_stall;

  assign out_rdy = {out1_ready, out0_ready};

  always_comb begin
    logic [WIDTH-1:0] cat;
    cat      = '0;
    at_last  = '0;
    take     = '0;
    asm_next = '0;
    for (int c = 0; c < 2; c++) begin
      at_last[c]  = (cnt_q[c] == LAST);
      take[c]     = in_valid & in_ready & (in_sel == c[0]);
      // Shift right so the first bit of a word ends up in bit 0 after WIDTH-1 shifts.
      cat         = {in_bit, sreg_q[c]};
      asm_next[c] = cat[WIDTH-1:1];
    end
  end

  // Only the selected channel can stall the input; the other channel's backpressure is irrelevant.
  assign sel_stall = at_last[in_sel] & vld_q[in_sel] & ~out_rdy[in_sel];
  assign in_ready  = rst_n & ~sel_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sreg_q <= '0;
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (take[c]) begin
          if (at_last[c]) begin
            data_q[c] <= {in_bit, sreg_q[c]};
            cnt_q[c]  <= '0;
          end else begin
            sreg_q[c] <= asm_next[c];
            cnt_q[c]  <= cnt_q[c] + CW'(1);
          end
        end
        // A completing bit wins over a same-edge consume: the new word replaces the old one.
        if (take[c] && at_last[c]) begin
          vld_q[c] <= 1'b1;
        end else if (out_rdy[c]) begin
          vld_q[c] <= 1'b0;
        end
      end
    end
  end

  assign out0_data  = data_q[0];
  assign out0_valid = vld_q[0];
  assign out1_data  = data_q[1];
  assign out1_valid = vld_q[1];

endmodule

// File: tb/tb_demux_word_router.sv
// Purpose : randomized and directed checking of demux_word_router against a word-level model.
// Latency : the model updates on each rising edge; outputs are compared on the falling edge.
// Backpr. : out0_ready/out1_ready are driven directly by the stimulus.
module tb_demux_word_router;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_bit;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out0_data;
  logic         out0_valid;
  logic         out0_ready;
  logic [W-1:0] out1_data;
  logic         out1_valid;
  logic         out1_ready;

  demux_word_router #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_bit     (in_bit),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: partial word value/count and held word per channel.
  int pv [2];
  int pn [2];
  int hw [2];
  bit hv [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_rdy();
    int c;
    bit ordy;
    if (!rst_n) return 1'b0;
    c    = in_sel ? 1 : 0;
    ordy = (c == 1) ? out1_ready : out0_ready;
    return !((pn[c] == W - 1) && hv[c] && !ordy);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      pv[c] = 0; pn[c] = 0; hw[c] = 0; hv[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit acc);
    bit done;
    bit ordy;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 2; c++) begin
      done = 1'b0;
      ordy = (c == 1) ? out1_ready : out0_ready;
      if (acc && (in_sel == c[0])) begin
        pv[c] = pv[c] + (int'(in_bit) << pn[c]);
        if (pn[c] == W - 1) begin
          hw[c] = pv[c]; hv[c] = 1'b1; pv[c] = 0; pn[c] = 0; done = 1'b1;
        end else begin
          pn[c] = pn[c] + 1;
        end
      end
      if (!done && ordy) hv[c] = 1'b0;
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    bit acc;
    @(negedge clk);
    chk("in_ready", in_ready, exp_rdy());
    chk("out0_valid", out0_valid, hv[0]);
    chk("out1_valid", out1_valid, hv[1]);
    chk("out0_data", out0_data, hw[0]);
    chk("out1_data", out1_data, hw[1]);
    acc = in_valid && exp_rdy();
    @(posedge clk);
    model_edge(acc);
    #1;
  endtask

  task automatic send(input logic s, input logic b);
    in_valid = 1'b1; in_sel = s; in_bit = b;
    step();
  endtask

  task automatic send_bits(input logic s, input logic [W-1:0] w, input int n);
    logic [W-1:0] v;
    v = w;
    for (int i = 0; i < n; i++) send(s, v[i]);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    logic [W-1:0] wd;
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_bit = 1'b1;
    out0_ready = 1'b0; out1_ready = 1'b0;
    model_reset();

    // Reset held for two edges with in_valid high.
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    step();

    // Single word 1,0,1,1,0,0,1,0 on channel 0.
    wd = 8'h4D;
    send_bits(1'b0, wd, W);
    chk("single_data", out0_data, 8'h4D);
    chk("single_vld0", out0_valid, 1'b1);
    chk("single_vld1", out1_valid, 1'b0);
    out0_ready = 1'b1; idle(); out0_ready = 1'b0;

    // Interleave: ch0 gets ones, ch1 gets zeros.
    for (int i = 0; i < 16; i++) begin
      send(i[0], ~i[0]);
      if (i == 14) begin
        chk("ilv_ch0_early_vld", out0_valid, 1'b1);
        chk("ilv_ch1_early_vld", out1_valid, 1'b0);
      end
    end
    chk("ilv_ch0_data", out0_data, 8'hFF);
    chk("ilv_ch1_data", out1_data, 8'h00);
    chk("ilv_ch1_vld", out1_valid, 1'b1);
    out0_ready = 1'b1; out1_ready = 1'b1; idle();
    out0_ready = 1'b0; out1_ready = 1'b0;

    // Backpressure on channel 0.
    wd = 8'hA5;
    send_bits(1'b0, wd, W);
    wd = 8'h3C;
    send_bits(1'b0, wd, W - 1);
    in_valid = 1'b1; in_sel = 1'b0; in_bit = wd[W-1];
    #2;
    chk("bp_stall", in_ready, 1'b0);
    chk("bp_hold", out0_data, 8'hA5);
    step();
    in_sel = 1'b1; in_bit = 1'b1;
    #2;
    chk("bp_other_ch", in_ready, 1'b1);
    step();
    in_sel = 1'b0; in_bit = wd[W-1]; out0_ready = 1'b1;
    #2;
    chk("bp_release", in_ready, 1'b1);
    step();
    chk("bp_refill_vld", out0_valid, 1'b1);
    chk("bp_refill_data", out0_data, 8'h3C);
    out0_ready = 1'b0;

    // Reset in the middle of a channel 1 word.
    wd = 8'h1F;
    send_bits(1'b1, wd, 5);
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    wd = 8'hFE;
    send_bits(1'b1, wd, W);
    chk("rstmid_data", out1_data, 8'hFE);
    chk("rstmid_vld", out1_valid, 1'b1);

    // Simultaneous consume on both channels with a ch1 refill, then ch0 completes.
    wd = 8'h5A; send_bits(1'b0, wd, W);
    wd = 8'h81; send_bits(1'b1, wd, W - 1);
    wd = 8'h0F; send_bits(1'b0, wd, W - 1);
    out0_ready = 1'b1; out1_ready = 1'b1;
    send(1'b1, 1'b1);
    chk("sim_ch1_vld", out1_valid, 1'b1);
    chk("sim_ch1_data", out1_data, 8'h81);
    chk("sim_ch0_vld", out0_valid, 1'b0);
    out0_ready = 1'b0; out1_ready = 1'b0;
    send(1'b0, 1'b0);
    chk("sim_ch0_data", out0_data, 8'h0F);
    chk("sim_ch0_vld2", out0_valid, 1'b1);
    chk("sim_ch1_keep", out1_data, 8'h81);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = 1'($urandom_range(0, 1));
      in_bit     = 1'($urandom_range(0, 1));
      out0_ready = ($urandom_range(0, 2) == 0);
      out1_ready = ($urandom_range(0, 1) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
